// File: rtl/ahb_sram_slave.sv
// AHB responder backed by a 2^ADDR_WDT-word internal memory.
// Accepts single and burst transfers (burst type is not checked), inserts
// WAIT_STATES wait cycles at the start of every legal data phase, and answers
// illegal accesses with a two-cycle ERROR response.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no data phase, or a zero-wait data phase completing this cycle
// WAIT  | legal data phase being stretched, wait_cnt cycles remain
// ERR1  | first ERROR cycle (hreadyout=0)
// ERR2  | second ERROR cycle (hreadyout=1), may accept a new address phase
module ahb_sram_slave #(
    parameter int DATA_WDT    = 32,
    parameter int ADDR_WDT    = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                i_hclk,
    input  logic                i_hreset_n,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic                o_hreadyout,
    output logic [1:0]          o_hresp,
    output logic [DATA_WDT-1:0] o_hrdata
);

    localparam int NBYTES  = DATA_WDT / 8;
    localparam int LANE_W  = $clog2(NBYTES);
    localparam int DEPTH   = 1 << ADDR_WDT;
    localparam int TOP_LSB = ADDR_WDT + LANE_W;
    localparam int CNT_W   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic                dp_valid;
    logic                dp_write;
    logic [ADDR_WDT-1:0] dp_word;
    logic [NBYTES-1:0]   dp_lanes;
    logic [DATA_WDT-1:0] mem [DEPTH];

    logic                accept;
    logic                size_bad;
    logic                align_bad;
    logic                range_bad;
    logic                illegal;
    logic [7:0]          size_mask;
    logic [NBYTES-1:0]   acc_lanes;

    // Burst type and the SEQ/NONSEQ distinction do not change the response.
    logic unused_sig;
    assign unused_sig = ^{i_hburst, i_htrans[0]};

    // Address phases are only taken while this slave is not stretching a data phase.
    assign accept    = i_hsel & i_hready & i_htrans[1] & o_hreadyout;
    assign size_mask = (8'd1 << i_hsize) - 8'd1;
    assign size_bad  = i_hsize > 3'(LANE_W);
    assign align_bad = |(i_haddr[7:0] & size_mask);
    assign range_bad = |i_haddr[31:TOP_LSB];
    assign illegal   = size_bad | align_bad | range_bad;

    // Byte b is written when it lies in the same size-aligned block as the address.
    always_comb begin
        acc_lanes = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if ((b >> i_hsize) == (int'(i_haddr[LANE_W-1:0]) >> i_hsize)) begin
                acc_lanes[b] = 1'b1;
            end
        end
    end

    // Response FSM and data-phase registers; outputs are registered.
    always_ff @(posedge i_hclk) begin
        if (!i_hreset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            o_hreadyout <= 1'b1;
            o_hresp     <= RESP_OKAY;
            dp_valid    <= 1'b0;
            dp_write    <= 1'b0;
            dp_word     <= '0;
            dp_lanes    <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CNT_W'(1)) begin
                        state       <= ST_IDLE;
                        o_hreadyout <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= RESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    o_hreadyout <= 1'b1;
                    o_hresp     <= RESP_OKAY;
                    dp_valid    <= 1'b0;
                    if (accept) begin
                        if (illegal) begin
                            state       <= ST_ERR1;
                            o_hreadyout <= 1'b0;
                            o_hresp     <= RESP_ERROR;
                        end else begin
                            dp_valid <= 1'b1;
                            dp_write <= i_hwrite;
                            dp_word  <= i_haddr[TOP_LSB-1:LANE_W];
                            dp_lanes <= acc_lanes;
                            if (WAIT_STATES > 0) begin
                                state       <= ST_WAIT;
                                wait_cnt    <= CNT_W'(WAIT_STATES);
                                o_hreadyout <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Write commits on the edge that ends the data phase; reset drops it.
    always_ff @(posedge i_hclk) begin
        if (i_hreset_n && dp_valid && dp_write && o_hreadyout) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (dp_lanes[b]) begin
                    mem[dp_word][8*b +: 8] <= i_hwdata[8*b +: 8];
                end
            end
        end
    end

    // Reads see the word after any write committed on the accepting edge.
    assign o_hrdata = (dp_valid && !dp_write) ? mem[dp_word] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: one zero-wait and one two-wait
// instance run the same directed scenarios, then independent random traffic,
// against a transaction-level model (per-transfer cycle schedules plus a
// byte-addressed memory image).
module tb_ahb_sram_slave;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } ap_t;

    typedef struct {
        bit          ready;
        bit [1:0]    resp;
        bit          done;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_hreset_n;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata_in [2];
    logic        hready_in [2];
    logic        hreadyout [2];
    logic [1:0]  hresp     [2];
    logic [31:0] hrdata    [2];

    ahb_sram_slave #(.DATA_WDT(32), .ADDR_WDT(10), .WAIT_STATES(0)) u_ws0 (
        .i_hclk(clk), .i_hreset_n(i_hreset_n), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
        .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]), .i_hburst(hburst[0]),
        .i_hwdata(hwdata_in[0]), .i_hready(hready_in[0]), .o_hreadyout(hreadyout[0]),
        .o_hresp(hresp[0]), .o_hrdata(hrdata[0])
    );

    ahb_sram_slave #(.DATA_WDT(32), .ADDR_WDT(10), .WAIT_STATES(2)) u_ws2 (
        .i_hclk(clk), .i_hreset_n(i_hreset_n), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
        .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]), .i_hburst(hburst[1]),
        .i_hwdata(hwdata_in[1]), .i_hready(hready_in[1]), .o_hreadyout(hreadyout[1]),
        .o_hresp(hresp[1]), .o_hrdata(hrdata[1])
    );

    ap_t         apq    [2][$];
    cyc_t        sch    [2][$];
    logic [31:0] rd_log [2][$];
    logic [31:0] mm     [2][1024];
    cyc_t        cur    [2];
    logic [31:0] wd_cur [2];
    bit          drv_valid [2];
    int          lowcnt [2];
    int          errcnt [2];
    bit          rand_mode;
    int          n_vec;
    int          n_miss;

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic cyc_t mk_cyc(bit rdy, bit [1:0] rsp, bit dn, bit w, logic [31:0] a, logic [2:0] s);
        cyc_t c;
        c.ready = rdy; c.resp = rsp; c.done = dn; c.wr = w; c.addr = a; c.size = s;
        return c;
    endfunction

    function automatic bit legal(logic [31:0] a, logic [2:0] s);
        int nb;
        nb = 1 << s;
        return (nb <= 4) && ((int'(a[7:0]) % nb) == 0) && (a < 32'h1000);
    endfunction

    function automatic void mm_write(int k, logic [31:0] a, logic [2:0] s, logic [31:0] d);
        int nb, off, w;
        nb  = 1 << s;
        off = int'(a[1:0]);
        w   = int'(a[11:2]);
        for (int b = off; b < off + nb; b++) mm[k][w][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] last_rd(int k);
        if (rd_log[k].size() == 0) return 32'hxxxx_xxxx;
        return rd_log[k][rd_log[k].size()-1];
    endfunction

    function automatic ap_t rand_ap();
        ap_t p;
        int kind;
        p.sel   = ($urandom_range(0, 9) != 0);
        kind    = $urandom_range(0, 9);
        p.trans = (kind < 2) ? 2'b00 : (kind < 3) ? 2'b01 : (kind < 7) ? 2'b10 : 2'b11;
        p.write = 1'($urandom_range(0, 1));
        p.size  = 3'($urandom_range(0, 2));
        p.burst = 3'($urandom_range(0, 7));
        p.wdata = $urandom;
        p.addr  = 32'($urandom_range(0, 31)) << 2;
        p.addr  = p.addr | ((32'($urandom_range(0, 3)) >> p.size) << p.size);
        case ($urandom_range(0, 15))
            0: p.size = 3'($urandom_range(3, 7));
            1: if (p.size != 3'd0) p.addr[0] = 1'b1;
            2: p.addr = p.addr | (32'h1 << $urandom_range(12, 31));
            default: ;
        endcase
        return p;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic put(bit w, logic [31:0] a, logic [2:0] s, logic [1:0] tr, logic [31:0] wd, logic [2:0] bu);
        ap_t p;
        p.sel = 1'b1; p.addr = a; p.trans = tr; p.write = w; p.size = s; p.burst = bu; p.wdata = wd;
        for (int k = 0; k < 2; k++) apq[k].push_back(p);
    endtask

    // One clock: advance the model over the edge, compare, then drive the next inputs.
    task automatic step();
        cyc_t ended;
        ap_t  p;
        logic [31:0] exp_d;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            ended = cur[k];
            if (!i_hreset_n) begin
                sch[k].delete();
            end else begin
                if (ended.ready && ended.done && ended.wr) mm_write(k, ended.addr, ended.size, wd_cur[k]);
                if (sch[k].size() > 0) void'(sch[k].pop_front());
                if (ended.ready && drv_valid[k]) begin
                    p = apq[k][0];
                    void'(apq[k].pop_front());
                    if (p.sel && p.trans[1]) begin
                        if (!legal(p.addr, p.size)) begin
                            sch[k].push_back(mk_cyc(1'b0, 2'b01, 1'b0, 1'b0, 32'h0, 3'd0));
                            sch[k].push_back(mk_cyc(1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 3'd0));
                        end else begin
                            for (int i = 0; i < ws_of(k); i++)
                                sch[k].push_back(mk_cyc(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 3'd0));
                            sch[k].push_back(mk_cyc(1'b1, 2'b00, 1'b1, p.write, p.addr, p.size));
                            if (p.write) wd_cur[k] = p.wdata;
                        end
                    end
                end
            end
            cur[k] = (sch[k].size() > 0) ? sch[k][0] : mk_cyc(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 3'd0);

            chk($sformatf("ws%0d hreadyout", ws_of(k)), 32'(hreadyout[k]), 32'(cur[k].ready));
            chk($sformatf("ws%0d hresp", ws_of(k)), 32'(hresp[k]), 32'(cur[k].resp));
            if (cur[k].ready) begin
                exp_d = (cur[k].done && !cur[k].wr) ? mm[k][int'(cur[k].addr[11:2])] : 32'h0;
                chk($sformatf("ws%0d hrdata", ws_of(k)), hrdata[k], exp_d);
                if (cur[k].done && !cur[k].wr) rd_log[k].push_back(hrdata[k]);
            end
            if (!hreadyout[k]) lowcnt[k]++;
            if (hresp[k] == 2'b01) errcnt[k]++;

            if (apq[k].size() == 0 && rand_mode) apq[k].push_back(rand_ap());
            hready_in[k] = cur[k].ready;
            hwdata_in[k] = wd_cur[k];
            if (apq[k].size() > 0) begin
                p            = apq[k][0];
                hsel[k]      = p.sel;
                haddr[k]     = p.addr;
                htrans[k]    = p.trans;
                hwrite[k]    = p.write;
                hsize[k]     = p.size;
                hburst[k]    = p.burst;
                drv_valid[k] = 1'b1;
            end else begin
                hsel[k]      = 1'b0;
                haddr[k]     = 32'h0;
                htrans[k]    = 2'b00;
                hwrite[k]    = 1'b0;
                hsize[k]     = 3'd2;
                hburst[k]    = 3'd0;
                drv_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((apq[0].size() + apq[1].size() + sch[0].size() + sch[1].size()) != 0 && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            n_miss++;
            $display("FAIL drain timeout: got %0d cycles, expected fewer than 300", n);
        end
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_miss = 0;
        rand_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cur[k]       = mk_cyc(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 3'd0);
            wd_cur[k]    = 32'h0;
            drv_valid[k] = 1'b0;
            lowcnt[k]    = 0;
            errcnt[k]    = 0;
            hsel[k] = 1'b0; haddr[k] = 32'h0; htrans[k] = 2'b00; hwrite[k] = 1'b0;
            hsize[k] = 3'd2; hburst[k] = 3'd0; hwdata_in[k] = 32'h0; hready_in[k] = 1'b1;
        end
        i_hreset_n = 1'b0;
        repeat (3) step();
        i_hreset_n = 1'b1;

        for (int i = 0; i < 32; i++) put(1'b1, 32'(i) << 2, 3'd2, 2'b10, $urandom, 3'd1);
        drain();

        // single write then read
        put(1'b1, 32'h10, 3'd2, 2'b10, 32'hDEAD_BEEF, 3'd0);
        put(1'b0, 32'h10, 3'd2, 2'b10, 32'h0, 3'd0);
        drain();
        for (int k = 0; k < 2; k++) chk("single rd", last_rd(k), 32'hDEAD_BEEF);

        // byte then halfword lane writes
        put(1'b1, 32'h13, 3'd0, 2'b10, 32'hAA00_0000, 3'd0);
        put(1'b0, 32'h10, 3'd2, 2'b10, 32'h0, 3'd0);
        drain();
        for (int k = 0; k < 2; k++) chk("byte lane rd", last_rd(k), 32'hAAAD_BEEF);
        put(1'b1, 32'h10, 3'd1, 2'b10, 32'h0000_5555, 3'd0);
        put(1'b0, 32'h10, 3'd2, 2'b10, 32'h0, 3'd0);
        drain();
        for (int k = 0; k < 2; k++) chk("half lane rd", last_rd(k), 32'hAAAD_5555);

        // illegal accesses
        for (int k = 0; k < 2; k++) errcnt[k] = 0;
        put(1'b0, 32'h1000, 3'd2, 2'b10, 32'h0, 3'd0);
        put(1'b1, 32'h11, 3'd1, 2'b10, 32'hFFFF_FFFF, 3'd0);
        put(1'b0, 32'h10, 3'd2, 2'b10, 32'h0, 3'd0);
        drain();
        for (int k = 0; k < 2; k++) begin
            chk("error cycles", 32'(errcnt[k]), 32'd4);
            chk("mem after error", last_rd(k), 32'hAAAD_5555);
        end

        // INCR4 write and read with wait states
        for (int k = 0; k < 2; k++) lowcnt[k] = 0;
        for (int i = 0; i < 4; i++)
            put(1'b1, 32'h40 + 32'(4*i), 3'd2, (i == 0) ? 2'b10 : 2'b11, 32'(i + 1), 3'd3);
        for (int i = 0; i < 4; i++)
            put(1'b0, 32'h40 + 32'(4*i), 3'd2, (i == 0) ? 2'b10 : 2'b11, 32'h0, 3'd3);
        drain();
        chk("ws0 wait cycles", 32'(lowcnt[0]), 32'd0);
        chk("ws2 wait cycles", 32'(lowcnt[1]), 32'd16);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++)
                chk("incr4 rd", rd_log[k][rd_log[k].size() - 4 + i], 32'(i + 1));

        // back-to-back write/read, BUSY mid-burst
        put(1'b1, 32'h0, 3'd2, 2'b10, 32'h0BAD_F00D, 3'd1);
        put(1'b0, 32'h0, 3'd2, 2'b10, 32'h0, 3'd1);
        drain();
        for (int k = 0; k < 2; k++) chk("raw rd", last_rd(k), 32'h0BAD_F00D);
        put(1'b0, 32'h40, 3'd2, 2'b10, 32'h0, 3'd3);
        put(1'b0, 32'h44, 3'd2, 2'b01, 32'h0, 3'd3);
        put(1'b0, 32'h44, 3'd2, 2'b11, 32'h0, 3'd3);
        drain();
        for (int k = 0; k < 2; k++) chk("busy burst rd", last_rd(k), 32'd2);

        // reset in the middle of a stretched write
        put(1'b1, 32'h20, 3'd2, 2'b10, 32'h1234_5678, 3'd0);
        drain();
        put(1'b1, 32'h20, 3'd2, 2'b10, 32'hCAFE_F00D, 3'd0);
        n = 0;
        while (apq[1].size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_miss++;
            $display("FAIL accept timeout: got %0d cycles, expected fewer than 50", n);
        end
        i_hreset_n = 1'b0;
        step();
        i_hreset_n = 1'b1;
        chk("ws2 post-reset hreadyout", 32'(hreadyout[1]), 32'd1);
        chk("ws2 post-reset hresp", 32'(hresp[1]), 32'd0);
        put(1'b0, 32'h20, 3'd2, 2'b10, 32'h0, 3'd0);
        drain();
        for (int k = 0; k < 2; k++) chk("dropped write", last_rd(k), 32'h1234_5678);

        // random traffic with occasional resets
        rand_mode = 1'b1;
        repeat (4000) begin
            i_hreset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        i_hreset_n = 1'b1;
        rand_mode = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
